// File: rtl/dcache_assoc_param.sv
// rtl/dcache_assoc_param.sv - parametrised N-way set-associative write-back data cache
//
// Sits between the datapath memory stage and the memory arbiter.
//   CLK, nRST            clock, asynchronous active-low reset
//   halt                 start writing back every dirty line, then store the hit count
//   dmemREN/dmemWEN      datapath read/write request (mutually exclusive)
//   dmemaddr/dmemstore   byte address and write data of the request
//   dhit/dmemload        request serviced this cycle (combinational) and read data
//   flushed              flush sequence finished; held until reset
//   dREN/dWEN/daddr      memory read/write request and byte address of the word
//   dstore/dload/dwait   memory write data, read data, busy (transfer completes when low)
module dcache_assoc_param #(
    parameter int          NSETS          = 8,
    parameter int          NWAYS          = 2,
    parameter int          WORDS          = 2,
    parameter logic [31:0] HIT_COUNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int BW  = $clog2(WORDS);
    localparam int IW  = $clog2(NSETS);
    localparam int TW  = 30 - BW - IW;
    localparam int WW  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int BWW = (BW > 0) ? BW : 1;

    typedef enum logic [2:0] {IDLE, WB, ALLOC, FLUSH, COUNT, DONE} state_t;

    state_t state, next_state;

    // line storage
    logic          line_valid [NSETS][NWAYS];
    logic          line_dirty [NSETS][NWAYS];
    logic [WW-1:0] line_age   [NSETS][NWAYS];
    logic [TW-1:0] line_tag   [NSETS][NWAYS];
    logic [31:0]   line_data  [NSETS][NWAYS][WORDS];

    // miss / flush bookkeeping
    logic [BWW-1:0] wcnt;
    logic [WW-1:0]  vway;
    logic [IW-1:0]  r_idx;
    logic [TW-1:0]  r_tag;
    logic [IW-1:0]  f_set;
    logic [WW-1:0]  f_way;
    logic           miss_pending;
    logic [31:0]    hit_cnt;

    // request decode
    logic [IW-1:0]  req_idx;
    logic [TW-1:0]  req_tag;
    logic [BWW-1:0] req_off;
    logic           req;

    assign req_idx = IW'(dmemaddr >> (2 + BW));
    assign req_tag = TW'(dmemaddr >> (2 + BW + IW));
    assign req_off = BWW'((dmemaddr >> 2) & 32'(WORDS - 1));
    assign req     = dmemREN | dmemWEN;

    logic          hit;
    logic [WW-1:0] hit_way;
    logic [WW-1:0] old_age;
    logic [WW-1:0] victim;
    logic          vic_found;
    logic          vic_dirty;
    logic          access_hit;
    logic          last_word;
    logic          fl_dirty;
    logic          fl_last_line;

    function automatic logic [31:0] line_addr(input logic [TW-1:0] t, input logic [IW-1:0] s,
                                              input logic [BWW-1:0] k);
        return (32'(t) << (2 + BW + IW)) | (32'(s) << (2 + BW)) | ((32'(k) & 32'(WORDS - 1)) << 2);
    endfunction

    // descending scan so the lowest matching way is the one left selected
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (line_valid[req_idx][w] && line_tag[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    assign old_age = line_age[req_idx][hit_way];

    // victim: first invalid way, else the oldest (age NWAYS-1)
    always_comb begin
        victim    = '0;
        vic_found = 1'b0;
        for (int w = 0; w < NWAYS; w++) begin
            if (!vic_found && !line_valid[req_idx][w]) begin
                victim    = WW'(w);
                vic_found = 1'b1;
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (line_age[req_idx][w] == WW'(NWAYS - 1)) victim = WW'(w);
            end
        end
    end

    assign vic_dirty    = line_valid[req_idx][victim] & line_dirty[req_idx][victim];
    assign access_hit   = hit & req & (state == IDLE) & ~halt;
    assign last_word    = (wcnt == BWW'(WORDS - 1));
    assign fl_dirty     = line_valid[f_set][f_way] & line_dirty[f_set][f_way];
    assign fl_last_line = (f_set == IW'(NSETS - 1)) && (f_way == WW'(NWAYS - 1));

    // state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (halt)             next_state = FLUSH;
                else if (req && !hit) next_state = vic_dirty ? WB : ALLOC;
            end
            WB:    if (!dwait && last_word) next_state = ALLOC;
            ALLOC: if (!dwait && last_word) next_state = IDLE;
            FLUSH: begin
                if (fl_dirty) begin
                    if (!dwait && last_word && fl_last_line) next_state = COUNT;
                end else if (fl_last_line) begin
                    next_state = COUNT;
                end
            end
            COUNT: if (!dwait) next_state = DONE;
            DONE:  next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // outputs
    always_comb begin
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        unique case (state)
            IDLE: begin
                dhit = access_hit;
                if (access_hit) dmemload = line_data[req_idx][hit_way][req_off];
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = line_addr(line_tag[r_idx][vway], r_idx, wcnt);
                dstore = line_data[r_idx][vway][wcnt];
            end
            ALLOC: begin
                dREN  = 1'b1;
                daddr = line_addr(r_tag, r_idx, wcnt);
            end
            FLUSH: begin
                if (fl_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = line_addr(line_tag[f_set][f_way], f_set, wcnt);
                    dstore = line_data[f_set][f_way][wcnt];
                end
            end
            COUNT: begin
                dWEN   = 1'b1;
                daddr  = HIT_COUNT_ADDR;
                dstore = hit_cnt;
            end
            DONE:    flushed = 1'b1;
            default: ;
        endcase
    end

    // counters, latched miss context, hit counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wcnt         <= '0;
            vway         <= '0;
            r_idx        <= '0;
            r_tag        <= '0;
            f_set        <= '0;
            f_way        <= '0;
            miss_pending <= 1'b0;
            hit_cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (halt) begin
                        f_set <= '0;
                        f_way <= '0;
                        wcnt  <= '0;
                    end else if (req && !hit) begin
                        vway  <= victim;
                        r_idx <= req_idx;
                        r_tag <= req_tag;
                        wcnt  <= '0;
                    end
                    // the first hit after a refill is the refilled request itself
                    if (access_hit) begin
                        if (miss_pending) miss_pending <= 1'b0;
                        else              hit_cnt      <= hit_cnt + 32'd1;
                    end
                end
                WB, ALLOC: begin
                    if (!dwait) begin
                        wcnt <= last_word ? '0 : wcnt + 1'b1;
                        if (state == ALLOC && last_word) miss_pending <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (!fl_dirty || (!dwait && last_word)) begin
                        wcnt <= '0;
                        if (f_way == WW'(NWAYS - 1)) begin
                            f_way <= '0;
                            f_set <= f_set + 1'b1;
                        end else begin
                            f_way <= f_way + 1'b1;
                        end
                    end else if (!dwait) begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // valid / dirty / age
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < NSETS; s++) begin
                for (int w = 0; w < NWAYS; w++) begin
                    line_valid[s][w] <= 1'b0;
                    line_dirty[s][w] <= 1'b0;
                    line_age[s][w]   <= WW'(w);
                end
            end
        end else begin
            if (access_hit) begin
                for (int w = 0; w < NWAYS; w++) begin
                    if (WW'(w) == hit_way)
                        line_age[req_idx][w] <= '0;
                    else if (line_age[req_idx][w] < old_age)
                        line_age[req_idx][w] <= line_age[req_idx][w] + 1'b1;
                end
                if (dmemWEN) line_dirty[req_idx][hit_way] <= 1'b1;
            end
            // a line only becomes valid once every word has arrived
            if (state == ALLOC && !dwait && last_word) begin
                line_valid[r_idx][vway] <= 1'b1;
                line_dirty[r_idx][vway] <= 1'b0;
            end
        end
    end

    // data and tag arrays carry no reset; validity guards them
    always_ff @(posedge CLK) begin
        if (access_hit && dmemWEN) line_data[req_idx][hit_way][req_off] <= dmemstore;
        if (state == ALLOC && !dwait) begin
            line_data[r_idx][vway][wcnt] <= dload;
            if (last_word) line_tag[r_idx][vway] <= r_tag;
        end
    end

endmodule

// File: tb/tb_dcache_assoc_param.sv
// tb/tb_dcache_assoc_param.sv - randomized bench for dcache_assoc_param against a line/recency model
module tb_dcache_assoc_param;

    localparam int          NS  = 4;
    localparam int          NW  = 4;
    localparam int          NWD = 4;
    localparam logic [31:0] HCA = 32'h3100;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        halt = 1'b0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemstore = '0;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload = '0;
    logic        dwait = 1'b0;

    dcache_assoc_param #(.NSETS(NS), .NWAYS(NW), .WORDS(NWD), .HIT_COUNT_ADDR(HCA)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int dw_mode = 0;  // 0 random wait, 1 never wait, 2 always wait

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       log_q[$];
    xfer_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];

    // reference cache: per-line contents plus a last-use timestamp per way
    bit          mvalid [NS][NW];
    bit          mdirty [NS][NW];
    logic [31:0] mtag   [NS][NW];
    logic [31:0] mdata  [NS][NW][NWD];
    int          stamp  [NS][NW];
    int          tick;
    logic [31:0] m_hits;

    bit          prev_wait_req = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_store = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'hAAAA0000;
    endfunction

    function automatic logic [31:0] la(input logic [31:0] t, input int s, input int k);
        return 32'(((t * NS + s) * NWD + k) * 4);
    endfunction

    // memory responder: picks dwait for the coming edge and commits that edge's transfer
    always @(negedge CLK) begin
        check_eq("ren_wen_excl", 32'(dREN & dWEN), 32'd0);
        if (prev_wait_req && (dREN || dWEN)) begin
            check_eq("stall_daddr", daddr, prev_addr);
            check_eq("stall_dstore", dstore, prev_store);
        end
        case (dw_mode)
            0:       dwait = ($urandom_range(0, 3) == 0);
            1:       dwait = 1'b0;
            default: dwait = 1'b1;
        endcase
        dload = mem_rd(daddr);
        if ((dREN || dWEN) && !dwait) begin
            if (dWEN) begin
                mem[daddr] = dstore;
                log_q.push_back('{1'b1, daddr, dstore});
            end else begin
                log_q.push_back('{1'b0, daddr, dload});
            end
        end
        prev_wait_req = (dREN || dWEN) && dwait;
        prev_addr     = daddr;
        prev_store    = dstore;
    end

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                mvalid[s][w] = 1'b0;
                mdirty[s][w] = 1'b0;
                stamp[s][w]  = -w;
            end
        end
        tick   = 0;
        m_hits = '0;
    endtask

    task automatic compare_log();
        int n;
        check_eq("xfer_count", log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq("xfer_we", 32'(log_q[i].we), 32'(exp_q[i].we));
            check_eq("xfer_addr", log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check_eq("xfer_data", log_q[i].data, exp_q[i].data);
        end
    endtask

    // one datapath access; called #1 after a rising edge
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int          s, o, hw, v, cyc;
        logic [31:0] t;
        bit          exp_hit;
        o  = int'((addr / 4) % NWD);
        s  = int'((addr / (4 * NWD)) % NS);
        t  = addr / (4 * NWD * NS);
        hw = -1;
        v  = -1;
        for (int w = NW - 1; w >= 0; w--) if (mvalid[s][w] && mtag[s][w] == t) hw = w;
        exp_hit = (hw >= 0);
        exp_q.delete();
        log_q.delete();
        if (!exp_hit) begin
            for (int w = NW - 1; w >= 0; w--) if (!mvalid[s][w]) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < NW; w++) if (stamp[s][w] < stamp[s][v]) v = w;
            end
            if (mvalid[s][v] && mdirty[s][v])
                for (int k = 0; k < NWD; k++) exp_q.push_back('{1'b1, la(mtag[s][v], s, k), mdata[s][v][k]});
            for (int k = 0; k < NWD; k++) exp_q.push_back('{1'b0, la(t, s, k), 32'h0});
        end
        dmemREN   = !we;
        dmemWEN   = we;
        dmemaddr  = addr;
        dmemstore = wd;
        @(negedge CLK);
        check_eq("hit_first", 32'(dhit), 32'(exp_hit));
        cyc = 0;
        while (!dhit && cyc < 400) begin
            @(negedge CLK);
            cyc++;
        end
        check_eq("req_done", 32'(dhit), 32'd1);
        if (!exp_hit) begin
            compare_log();
            for (int k = 0; k < NWD; k++) mdata[s][v][k] = mem_rd(la(t, s, k));
            mvalid[s][v] = 1'b1;
            mdirty[s][v] = 1'b0;
            mtag[s][v]   = t;
            hw           = v;
        end else begin
            m_hits = m_hits + 32'd1;
        end
        if (!we) check_eq("rdata", dmemload, mdata[s][hw][o]);
        else begin
            mdata[s][hw][o] = wd;
            mdirty[s][hw]   = 1'b1;
        end
        tick++;
        stamp[s][hw] = tick;
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic do_flush();
        int n, f;
        exp_q.delete();
        f = 0;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                if (mvalid[s][w] && mdirty[s][w]) begin
                    for (int k = 0; k < NWD; k++) exp_q.push_back('{1'b1, la(mtag[s][w], s, k), mdata[s][w][k]});
                    f += NWD;
                end else begin
                    f += 1;
                end
            end
        end
        exp_q.push_back('{1'b1, HCA, m_hits});
        dw_mode = 1;
        log_q.delete();
        halt = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(negedge CLK);
            n++;
            if (dWEN && daddr == HCA) break;
        end
        // one IDLE negedge before FLUSH, then f FLUSH cycles, then COUNT
        check_eq("flush_cycles", n, f + 2);
        @(posedge CLK);
        #1;
        compare_log();
        repeat (3) begin
            @(negedge CLK);
            check_eq("flushed", 32'(flushed), 32'd1);
            check_eq("done_idle_bus", 32'(dREN | dWEN), 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        check_eq("rst_dhit", 32'(dhit), 32'd0);
        check_eq("rst_dren", 32'(dREN), 32'd0);
        check_eq("rst_dwen", 32'(dWEN), 32'd0);
        check_eq("rst_flushed", 32'(flushed), 32'd0);
        check_eq("rst_daddr", daddr, 32'd0);
        check_eq("rst_dstore", dstore, 32'd0);
        check_eq("rst_dmemload", dmemload, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // cold miss, hit, write hit, read back
        access(1'b0, 32'h40, '0);
        access(1'b0, 32'h44, '0);
        access(1'b1, 32'h44, 32'hDEADBEEF);
        access(1'b0, 32'h44, '0);

        // LRU in set 1: A, B(dirty), C, D, A again, then E must evict B
        access(1'b0, 32'h050, '0);
        access(1'b1, 32'h094, 32'h12345678);
        access(1'b0, 32'h0D0, '0);
        access(1'b0, 32'h110, '0);
        access(1'b0, 32'h058, '0);
        access(1'b0, 32'h150, '0);
        access(1'b0, 32'h05C, '0);
        access(1'b0, 32'h0D4, '0);
        access(1'b0, 32'h118, '0);
        access(1'b0, 32'h098, '0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2);
            access($urandom_range(0, 9) < 4, a, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge CLK);
                #1;
            end
        end

        do_flush();

        // reset out of DONE, then stall mid-refill and reset asynchronously
        nRST = 1'b0;
        halt = 1'b0;
        model_reset();
        dw_mode = 2;
        @(negedge CLK);
        check_eq("rst2_flushed", 32'(flushed), 32'd0);
        @(posedge CLK);
        #1;
        nRST     = 1'b1;
        dmemREN  = 1'b1;
        dmemaddr = 32'h80;
        @(negedge CLK);
        check_eq("stall_miss", 32'(dhit), 32'd0);
        @(negedge CLK);
        check_eq("alloc_dren", 32'(dREN), 32'd1);
        check_eq("alloc_addr0", daddr, 32'h80);
        repeat (5) begin
            @(negedge CLK);
            check_eq("hold_addr", daddr, 32'h80);
            check_eq("hold_dren", 32'(dREN), 32'd1);
        end
        @(posedge CLK);
        #1;
        dw_mode = 1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        dw_mode = 2;
        @(negedge CLK);
        check_eq("alloc_addr1", daddr, 32'h84);
        #2;
        nRST = 1'b0;
        #1;
        check_eq("async_rst_dren", 32'(dREN), 32'd0);
        check_eq("async_rst_daddr", daddr, 32'd0);
        dmemREN = 1'b0;
        dw_mode = 0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        access(1'b0, 32'h80, '0);
        access(1'b0, 32'h84, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_assoc_param.md
Name: dcache_assoc_param

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the datapath memory stage and the memory arbiter.
- Generalises the fixed 8-set, 2-way, 2-word dcache to configurable sets, ways and block size.
- Adds true LRU for up to 4 ways, correct write-hit update with dirty marking, and a flush that skips clean lines.
- On halt, writes back every dirty line, then stores the hit counter to a configurable address and asserts flushed.

Parameters:
- NSETS, 8: number of sets; power of 2, 2..64.
- NWAYS, 2: associativity; one of 1, 2, 4.
- WORDS, 2: 32-bit words per block; one of 1, 2, 4, 8.
- HIT_COUNT_ADDR, 32'h3100: word address for the hit-counter store at the end of a flush.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; asynchronous, active-low.
- halt  in  1  datapath halt; starts the flush.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request; never asserted together with dmemREN.
- dmemaddr  in  32  byte address; bits [1:0] ignored.
- dmemstore  in  32  write data.
- dhit  out  1  request serviced this cycle.
- dmemload  out  32  read data, valid while dhit=1.
- flushed  out  1  flush complete; sticky until reset.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data, valid when dwait=0.
- dwait  in  1  memory busy; a transfer completes in the cycle dwait=0.

Behaviour:
- Address split: [1:0] byte, next log2(WORDS) bits blkoff, next log2(NSETS) bits idx, remaining bits tag.
- Line state: valid, dirty, tag, WORDS data words, and a per-way age of log2(NWAYS) bits.
- Reset (asynchronous):
  - all valid and dirty bits cleared; way i age = i; state IDLE.
  - hit counter 0, miss_pending 0.
  - all outputs 0.
- Hit: hit = some way in set idx is valid with a matching tag; the lowest matching way wins.
- dhit = hit & (dmemREN|dmemWEN) & state==IDLE & ~halt. It is combinational, giving zero-cycle hit latency.
- Read hit: dmemload = hit-way word [blkoff].
- Write hit: on that clock edge, the word takes dmemstore and dirty is set.
- LRU update on every dhit:
  - the accessed way's age becomes 0;
  - ways with age below the accessed way's old age increment;
  - others are unchanged.
- Victim: the lowest-index invalid way; otherwise the way with age = NWAYS-1.
- The victim is latched on miss detection and held until the refill completes.
- States: IDLE, WB, ALLOC, FLUSH, COUNT, DONE.
- IDLE:
  - halt → FLUSH, with priority over a pending request.
  - On miss with a request → WB if the victim is valid&dirty, else ALLOC.
  - Word counter cleared on entry to WB or ALLOC.
- WB:
  - dWEN=1, daddr={victim tag, idx, word counter, 2'b00}, dstore=victim word.
  - Counter advances when dwait=0.
  - After word WORDS-1 completes → ALLOC with the counter cleared.
- ALLOC:
  - dREN=1, daddr={req tag, idx, word counter, 2'b00}.
  - On dwait=0, dload is written to the victim word.
  - After the last word: valid=1, dirty=0, tag written, miss_pending=1 → IDLE.
  - The request then hits and completes normally in IDLE.
- Hit counter (32-bit, wraps):
  - increments on each dhit with miss_pending=0;
  - a dhit with miss_pending=1 clears miss_pending instead.
  - The count therefore equals requests serviced without a refill.
- FLUSH:
  - Iterates set 0..NSETS-1, way 0..NWAYS-1, word 0..WORDS-1.
  - A valid&dirty line drives dWEN with its reconstructed address and data; each word advances on dwait=0.
  - A clean or invalid line is skipped in exactly 1 cycle with no memory request.
  - After the last line → COUNT.
- COUNT: dWEN=1, daddr=HIT_COUNT_ADDR, dstore=hit counter. On dwait=0 → DONE.
- DONE: flushed=1, no memory requests; stays until reset.
- Memory handshake:
  - dREN and dWEN are never both 1.
  - daddr and dstore stay stable while dwait=1.
  - dREN=dWEN=0 in IDLE and DONE.
- dwait held high for any duration: the state holds with no corruption.
- Reset during WB/ALLOC/FLUSH: immediate return to the reset state. A partial line is never marked valid.

Test Plan:
- Cold read at 0x40 (defaults) → dhit=0; dREN at daddr 0x40 then 0x44; dload 0xAAAA0001/0xAAAA0002. Next cycle dhit=1, dmemload=0xAAAA0001; hit counter stays 0.
- Then write 0xDEADBEEF to 0x44 → dhit=1 the same cycle. A read of 0x44 returns 0xDEADBEEF; the counter is 2 after both accesses.
- Read 0x80 (idx0, way1 filled), then read 0xC0 → victim is the 0x40 line (LRU, dirty). WB stores 0xAAAA0001@0x40 and 0xDEADBEEF@0x44, then ALLOC reads 0xC0/0xC4.
- Assert halt with a single dirty line → only its WORDS writes are issued, plus the skip cycles for clean lines. Then dWEN@0x3100 with dstore = hit count, then flushed=1 held.
- NWAYS=4, WORDS=4, NSETS=4: touch tags A,B,C,D in one set, re-read A, then miss on E → C... victim is B (the oldest). ALLOC issues 4 reads at consecutive word addresses.
- Hold dwait=1 for 5 cycles mid-ALLOC, then pulse nRST low → daddr stable during the stall. After reset: dREN=0, all lines invalid, and a re-read of the same address misses.
